// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared geometry constants, FSM state type and line-metadata type
//            for the direct-mapped write-back data cache.
// Revision : 1.0  initial release
// ============================================================================
package dcache_pkg;

  localparam int NUM_LINES  = 8;                 // power of two, >= 2
  localparam int LINE_BYTES = 16;                // four 32-bit words
  localparam int LINE_W     = LINE_BYTES * 8;    // 128-bit memory port
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = 32 - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_meta_t;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_array
// Purpose  : Line store for the data cache: valid/dirty/tag metadata plus
//            128-bit line data. One combinational read port, a word-write
//            port (store hit, marks dirty) and a line-write port (refill,
//            marks valid and clean). Only valid/dirty are cleared on reset.
// Revision : 1.0  initial release
// ============================================================================
module dcache_array
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_data_o,
  input  logic               ww_en_i,
  input  logic [INDEX_W-1:0] ww_idx_i,
  input  logic [1:0]         ww_word_i,
  input  logic [31:0]        ww_data_i,
  input  logic               lw_en_i,
  input  logic [INDEX_W-1:0] lw_idx_i,
  input  logic [TAG_W-1:0]   lw_tag_i,
  input  logic [LINE_W-1:0]  lw_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Valid/dirty flags: refill makes a line valid+clean, a store hit makes it dirty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lw_en_i) begin
      valid_q[lw_idx_i] <= 1'b1;
      dirty_q[lw_idx_i] <= 1'b0;
    end else if (ww_en_i) begin
      dirty_q[ww_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage: no reset, contents are meaningless until valid.
  always_ff @(posedge clk_i) begin
    if (lw_en_i) begin
      tag_q[lw_idx_i]  <= lw_tag_i;
      data_q[lw_idx_i] <= lw_data_i;
    end else if (ww_en_i) begin
      data_q[ww_idx_i][{ww_word_i, 5'b00000} +: 32] <= ww_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate data cache controller.
//            Zero-cycle hits; on a miss it stalls, writes back a dirty victim
//            and refills the line over a req/ack memory port.
// Revision : 1.0  initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          MemRead_i,
  input  logic          MemWrite_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   write_data_i,
  output logic [31:0]   data_o,
  output logic          stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [127:0]  mem_wdata_o,
  input  logic [127:0]  mem_rdata_i,
  input  logic          mem_ack_i
);

  state_e state_q, state_d;
  // Line address of the access that missed; keeps the memory transaction
  // stable even if the pipeline drops or changes its request mid-miss.
  logic [31:OFFSET_W] miss_line_q, miss_line_d;

  logic               w_req;
  logic [INDEX_W-1:0] w_req_idx;
  logic [TAG_W-1:0]   w_req_tag;
  logic [INDEX_W-1:0] w_miss_idx;
  logic [INDEX_W-1:0] w_rd_idx;
  logic               w_hit;
  logic               w_ww_en;
  logic               w_lw_en;
  line_meta_t         w_meta;
  logic [LINE_W-1:0]  w_rd_data;
  logic               w_unused;

  assign w_req      = MemRead_i | MemWrite_i;
  assign w_req_idx  = addr_i[OFFSET_W +: INDEX_W];
  assign w_req_tag  = addr_i[31 -: TAG_W];
  assign w_miss_idx = miss_line_q[OFFSET_W +: INDEX_W];
  // In IDLE the array is looked up by the live request; during a miss it
  // is pointed at the victim/refill line.
  assign w_rd_idx   = (state_q == IDLE) ? w_req_idx : w_miss_idx;
  assign w_hit      = w_meta.valid && (w_meta.tag == w_req_tag);
  assign w_unused   = ^addr_i[1:0];

  dcache_array u_array (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rd_idx_i   (w_rd_idx),
    .rd_valid_o (w_meta.valid),
    .rd_dirty_o (w_meta.dirty),
    .rd_tag_o   (w_meta.tag),
    .rd_data_o  (w_rd_data),
    .ww_en_i    (w_ww_en),
    .ww_idx_i   (w_req_idx),
    .ww_word_i  (addr_i[3:2]),
    .ww_data_i  (write_data_i),
    .lw_en_i    (w_lw_en),
    .lw_idx_i   (w_miss_idx),
    .lw_tag_i   (miss_line_q[31 -: TAG_W]),
    .lw_data_i  (mem_rdata_i)
  );

  // State and captured miss address registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
    end
  end

  // Next-state, hit/miss handling and memory-port outputs.
  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    stall_o     = 1'b0;
    data_o      = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    w_ww_en     = 1'b0;
    w_lw_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            // Simultaneous read+write is treated as a write.
            if (MemWrite_i) w_ww_en = 1'b1;
            else            data_o  = w_rd_data[{addr_i[3:2], 5'b00000} +: 32];
          end else begin
            stall_o     = 1'b1;
            miss_line_d = addr_i[31:OFFSET_W];
            state_d     = (w_meta.valid && w_meta.dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {w_meta.tag, w_miss_idx, {OFFSET_W{1'b0}}};
        mem_wdata_o = w_rd_data;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_line_q, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          w_lw_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller that sits between the MEM stage and data memory. It serves loads and stores from a small on-chip line store and returns hits in zero cycles. It stalls the pipeline on a miss while it writes back a dirty victim and refills the line over a request/acknowledge memory port with arbitrary latency.

## Interface
- NUM_LINES, 8: number of cache lines; power of two, ≥2.
- LINE_BYTES, 16: line size (4 words); fixed, gives the 128-bit memory port.
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- MemRead_i  in  1  load request from MEM stage
- MemWrite_i  in  1  store request from MEM stage
- addr_i  in  32  byte address, word-aligned (addr_i[1:0]=0)
- write_data_i  in  32  store data
- data_o  out  32  load data to MEM/WB
- stall_o  out  1  pipeline stall; request must be held while 1
- mem_req_o  out  1  memory transaction request
- mem_we_o  out  1  1 = write-back, 0 = refill
- mem_addr_o  out  32  line-aligned address (low 4 bits 0)
- mem_wdata_o  out  128  victim line data
- mem_rdata_i  in  128  refill line data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- Address split: offset [3:0] (word select [3:2]), index [3+log2(NUM_LINES):4], tag = remaining upper bits.
- Per line: valid, dirty, tag, 128-bit data. Word w of a line occupies bits [32w+31:32w].
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit (valid and tag equal):
  - Read: data_o = selected word.
  - Write: the word is updated at the edge and dirty is set to 1.
  - stall_o=0.
- IDLE, miss with a request active: stall_o=1 in the same cycle. If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 4'h0}, mem_wdata_o=victim line. On mem_ack_i, go to ALLOCATE.
- ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 4'h0}. On mem_ack_i, the line takes mem_rdata_i with valid=1, dirty=0 and the new tag, then returns to IDLE. In IDLE the access re-evaluates as a hit: loads return data, stores merge and set dirty.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until mem_ack_i. mem_ack_i is ignored in IDLE.
- MemRead_i and MemWrite_i both 1: handled as a write.
- No request: stall_o=0, data_o=0, no state change.
- If the request drops mid-miss, the current memory transaction still completes. There is no abort.
- Reset (asynchronous): state=IDLE, all valid and dirty cleared, mem_req_o=0, mem_we_o=0. The data array is not reset. Reset mid-transaction abandons the transaction, loses dirty data, and drops mem_req_o immediately.

## Timing
- Hit latency is 0 cycles: data_o and stall_o are combinational from the request and array state.
- Miss detected in cycle 0: stall_o=1 and the state moves at the cycle 0/1 edge. mem_req_o is first asserted in cycle 1.
- If the final mem_ack_i arrives in cycle c, stall_o=0 and the access completes in cycle c+1.
- Dirty miss: the write-back ack in cycle a gives ALLOCATE with refill request from cycle a+1.
- mem_ack_i in the same cycle as mem_req_o first rises is legal, giving a minimum 1-cycle memory latency.

## Structure
- Package dcache_pkg holds:
  - LINE_BYTES and the offset/index/tag width constants derived from NUM_LINES.
  - The state enum (IDLE/WRITEBACK/ALLOCATE).
  - The line-metadata struct {valid, dirty, tag}.
- One sub-module, dcache_array: metadata and data storage with one read port (combinational), word-write and line-write ports, and async clear of valid/dirty. The FSM and hit logic live in dcache_ctrl.

## Test plan
1. Cold read after reset (NUM_LINES=8): read 0x40, memory acks after 3 cycles with line {0x44444444,0x33333333,0x22222222,0x11111111} (word3..word0).
   - One refill request appears with mem_addr_o=0x40, mem_we_o=0.
   - stall_o stays 1 until the cycle after ack, then data_o=0x11111111.
2. Read hit 0x44: data_o=0x22222222 in the same cycle, stall_o=0, no mem_req_o.
3. Write hit 0x48 with 0xCAFEF00D: stall_o=0. A following read of 0x48 returns 0xCAFEF00D.
4. Conflict read 0xC0 (index 4, new tag):
   - Write-back first: mem_we_o=1, mem_addr_o=0x40, mem_wdata_o word2=0xCAFEF00D.
   - Then refill from 0xC0.
   - stall_o=1 through both acks.
5. Write miss to clean line 0x100 with 0x5A5A5A5A:
   - Refill only, no write-back. The word is merged after refill.
   - A later conflicting read at 0x180 first writes back 0x100 containing 0x5A5A5A5A.
6. Reset during ALLOCATE:
   - mem_req_o drops immediately while rst_n_i is 0.
   - After release, read 0x44 misses and refills from 0x40.
